// File: rtl/sample_bist.sv
// Built-in self-test for f = (x ^ (y & z)) | ~w: sweeps all 16 vectors into an external
// 'sample' instance, checks each response against a golden model and records failures.
module sample_bist #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_x,
  output logic             o_y,
  output logic             o_z,
  output logic             o_w,
  input  logic             i_f,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic             o_fail_vld,
  output logic [3:0]       o_fail_vec
);

  localparam int unsigned      CntW    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CntW-1:0]  CntLoad = CntW'(SETTLE);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [ERR_W-1:0] ErrMax  = '1;

  typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

  state_e r_state, w_state_nxt;

  logic [3:0]       r_vec, w_vec_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic             r_fail_vld, w_fail_vld_nxt;
  logic [3:0]       r_fail_vec, w_fail_vec_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;

  logic w_golden;
  logic w_accept;
  logic w_mismatch;
  logic w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle, StDone: if (i_start) w_state_nxt = StWait;
      // Leave on the edge where the counter reaches zero.
      StWait:         if (r_cnt == CntOne) w_state_nxt = StCheck;
      StCheck:        w_state_nxt = (r_vec == 4'hF) ? StDone : StWait;
      default:        w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_golden   = (r_vec[3] ^ (r_vec[2] & r_vec[1])) | ~r_vec[0];
    w_accept   = ((r_state == StIdle) || (r_state == StDone)) && i_start;
    w_mismatch = (r_state == StCheck) && (i_f != w_golden);
    w_last     = (r_vec == 4'hF);

    w_vec_nxt      = r_vec;
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = r_err;
    w_fail_vld_nxt = r_fail_vld;
    w_fail_vec_nxt = r_fail_vec;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_pass_nxt     = r_pass;

    if (w_accept) begin
      w_vec_nxt      = 4'h0;
      w_cnt_nxt      = CntLoad;
      w_err_nxt      = '0;
      w_fail_vld_nxt = 1'b0;
      w_fail_vec_nxt = 4'h0;
      w_busy_nxt     = 1'b1;
      w_done_nxt     = 1'b0;
      w_pass_nxt     = 1'b0;
    end else if (r_state == StWait) begin
      w_cnt_nxt = r_cnt - CntOne;
    end else if (r_state == StCheck) begin
      if (w_mismatch && (r_err != ErrMax)) begin
        w_err_nxt = r_err + ERR_W'(1);
      end
      if (w_mismatch && !r_fail_vld) begin
        w_fail_vld_nxt = 1'b1;
        w_fail_vec_nxt = r_vec;
      end
      if (!w_last) begin
        w_vec_nxt = r_vec + 4'h1;
        w_cnt_nxt = CntLoad;
      end else begin
        // Verdict must include a mismatch on the final vector.
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
        w_pass_nxt = (w_err_nxt == '0);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vec      <= 4'h0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_fail_vld <= 1'b0;
      r_fail_vec <= 4'h0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_vec      <= w_vec_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_fail_vld <= w_fail_vld_nxt;
      r_fail_vec <= w_fail_vec_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
    end
  end

  assign {o_x, o_y, o_z, o_w} = r_vec;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_count = r_err;
  assign o_fail_vld  = r_fail_vld;
  assign o_fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_sample_bist.sv
// Directed bench for sample_bist: real/stuck-0/stuck-1 responders, saturation with a narrow
// counter, ignored restart, asynchronous mid-sweep reset and restart from DONE.
module tb_sample_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;  // 0: real sample, 1: f stuck 0, 2: f stuck 1

  logic       x, y, z, w, f;
  logic       busy, done, pass, fail_vld;
  logic [4:0] err_count;
  logic [3:0] fail_vec;
  logic [3:0] vec_obs;

  logic       sx, sy, sz, sw;
  logic       s_busy, s_done, s_pass, s_fail_vld;
  logic [2:0] s_err_count;
  logic [3:0] s_fail_vec;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign vec_obs = {x, y, z, w};
  assign f = (mode == 2'd0) ? ((x ^ (y & z)) | ~w) : (mode == 2'd2);

  sample_bist #(.SETTLE(2), .ERR_W(5)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_x(x), .o_y(y), .o_z(z), .o_w(w), .i_f(f),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_count(err_count), .o_fail_vld(fail_vld), .o_fail_vec(fail_vec)
  );

  sample_bist #(.SETTLE(2), .ERR_W(3)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_x(sx), .o_y(sy), .o_z(sz), .o_w(sw), .i_f(1'b0),
    .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
    .o_err_count(s_err_count), .o_fail_vld(s_fail_vld), .o_fail_vec(s_fail_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start is seen at the edge between the two negedges; n counts edges after it.
  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
  endtask

  task automatic wait_done;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_fvld"}, 32'(fail_vld), 32'd0);
    check({tag, "_fvec"}, 32'(fail_vec), 32'd0);
    check({tag, "_xyzw"}, 32'(vec_obs), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    n     = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Real responder: clean pass in 48 cycles.
    pulse_start();
    check("real_busy_on", 32'(busy), 32'd1);
    check("real_vec0", 32'(vec_obs), 32'd0);
    n++;
    @(negedge clk);
    check("real_pre_done", 32'(done), 32'd0);
    n--;
    wait_done();
    check("real_cycles", 32'(n + 1), 32'd48);
    check("real_pass", 32'(pass), 32'd1);
    check("real_err", 32'(err_count), 32'd0);
    check("real_fvld", 32'(fail_vld), 32'd0);
    check("real_busy_off", 32'(busy), 32'd0);
    check("real_xyzw", 32'(vec_obs), 32'hF);

    // f stuck 0: golden is 1 on 12 vectors, first at 0000.
    mode = 2'd1;
    pulse_start();
    check("t0_done_clr", 32'(done), 32'd0);
    wait_done();
    check("t0_cycles", 32'(n), 32'd48);
    check("t0_err", 32'(err_count), 32'd12);
    check("t0_pass", 32'(pass), 32'd0);
    check("t0_fvld", 32'(fail_vld), 32'd1);
    check("t0_fvec", 32'(fail_vec), 32'h0);
    check("sat_done", 32'(s_done), 32'd1);
    check("sat_err", 32'(s_err_count), 32'd7);
    check("sat_pass", 32'(s_pass), 32'd0);

    // f stuck 1: golden is 0 on 4 vectors, first at 0001.
    mode = 2'd2;
    pulse_start();
    wait_done();
    check("t1_err", 32'(err_count), 32'd4);
    check("t1_pass", 32'(pass), 32'd0);
    check("t1_fvld", 32'(fail_vld), 32'd1);
    check("t1_fvec", 32'(fail_vec), 32'h1);

    // Restart from a failing DONE with the real responder.
    mode = 2'd0;
    pulse_start();
    check("rs_err_clr", 32'(err_count), 32'd0);
    check("rs_fvld_clr", 32'(fail_vld), 32'd0);
    wait_done();
    check("rs_cycles", 32'(n), 32'd48);
    check("rs_pass", 32'(pass), 32'd1);
    check("rs_err", 32'(err_count), 32'd0);

    // Start re-pulsed at cycle 10 is ignored.
    mode = 2'd1;
    pulse_start();
    while (n < 9) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    check("ign_vec", 32'(vec_obs), 32'd3);
    wait_done();
    check("ign_cycles", 32'(n), 32'd48);
    check("ign_err", 32'(err_count), 32'd12);

    // Asynchronous reset mid-sweep.
    pulse_start();
    while (n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_vec", 32'(vec_obs), 32'd6);
    check("mid_err", 32'(err_count), 32'd3);
    check("mid_fvld", 32'(fail_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);

    // Fresh sweep after reset.
    mode = 2'd0;
    pulse_start();
    wait_done();
    check("final_cycles", 32'(n), 32'd48);
    check("final_pass", 32'(pass), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
